rv32im_wb_ram_slave: RTL and testbench

Wishbone classic-cycle slave wrapping an inferable word-organised RAM. It is the responder end of the core's load/store bus master. It accepts single-beat reads and writes with byte-lane selects, inserts a configurable number of wait states, and returns `ack_o` or `err_o`. It sits on the data bus between the memory stage and on-chip RAM.

---
 rtl/rv32im_wb_ram_slave.sv | 186 ++++++++++++++++++
 tb/tb_rv32im_wb_ram_slave.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32im_wb_ram_slave.sv
// Wishbone classic-cycle slave in front of a word-organised RAM with byte lanes,
// programmable wait states and an error response for illegal requests.
module rv32im_wb_ram_slave #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk_i,
    input  logic              clear_ni,
    input  logic [XLEN-1:2]   adr_i,
    input  logic [XLEN-1:0]   dat_i,
    output logic [XLEN-1:0]   dat_o,
    input  logic [3:0]        sel_i,
    input  logic              we_i,
    input  logic              stb_i,
    input  logic              cyc_i,
    output logic              ack_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned NUM_LANES = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [3:0]            r_sel;
    logic                  r_we;
    logic [XLEN-1:0]       r_dat;
    logic [XLEN-1:0]       r_dat_o;
    logic                  r_ack;
    logic                  r_err;
    logic                  r_busy;
    logic [XLEN-1:0]       r_mem [DEPTH];

    logic w_req;
    logic w_sel_ok;
    logic w_in_range;
    logic w_legal;
    logic w_latch;
    logic w_access;
    logic w_ack_nxt;
    logic w_err_nxt;
    logic w_busy_nxt;

    assign w_req   = cyc_i & stb_i;
    assign w_legal = w_sel_ok & w_in_range;

    // Upper address bits must be zero unless the RAM spans the whole space
    generate
        if (ADDR_WIDTH < XLEN - 2) begin : g_range
            assign w_in_range = ~|adr_i[XLEN-1:ADDR_WIDTH+2];
        end else begin : g_no_range
            assign w_in_range = 1'b1;
        end
    endgenerate

    // Only naturally aligned byte, half and word lane patterns are accepted
    always_comb begin
        w_sel_ok = 1'b0;
        case (sel_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: w_sel_ok = 1'b1;
            default:                   w_sel_ok = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge clear_ni) begin
        if (!clear_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; RESP always lasts one cycle so stb_i is never re-sampled there
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = w_legal ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (!cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output/control decode: next values of the registered outputs and datapath strobes
    always_comb begin
        w_ack_nxt = 1'b0;
        w_err_nxt = 1'b0;
        w_latch   = 1'b0;
        w_access  = 1'b0;
        w_cnt_nxt = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_legal) begin
                        w_latch   = 1'b1;
                        w_cnt_nxt = CNT_W'(WAIT_STATES);
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cyc_i) begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else begin
                        w_access  = 1'b1;
                        w_ack_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // Registered outputs, wait counter and latched request
    always_ff @(posedge clk_i or negedge clear_ni) begin
        if (!clear_ni) begin
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_dat_o <= '0;
            r_adr   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_ack  <= w_ack_nxt;
            r_err  <= w_err_nxt;
            r_busy <= w_busy_nxt;
            if (w_latch) begin
                r_adr <= adr_i[ADDR_WIDTH+1:2];
                r_sel <= sel_i;
                r_we  <= we_i;
                r_dat <= dat_i;
            end
            if (w_access && !r_we) begin
                r_dat_o <= r_mem[r_adr];
            end
        end
    end

    // RAM write port with byte-lane enables; contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (w_access && r_we) begin
            for (int b = 0; b < NUM_LANES; b++) begin
                if (r_sel[b]) begin
                    r_mem[r_adr][b*8 +: 8] <= r_dat[b*8 +: 8];
                end
            end
        end
    end

    assign dat_o  = r_dat_o;
    assign ack_o  = r_ack;
    assign err_o  = r_err;
    assign busy_o = r_busy;

endmodule

// File: tb/tb_rv32im_wb_ram_slave.sv
// Scoreboard bench: two slaves (WAIT_STATES=1 and 0) driven by a Wishbone master
// task; expected responses are queued at issue time and a monitor checks them.
module tb_rv32im_wb_ram_slave;

    typedef struct {
        int          k;
        bit          is_err;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        clear_n;
    logic [31:2] adr   [2];
    logic [31:0] dat_w [2];
    logic [31:0] dat_r [2];
    logic [3:0]  sel   [2];
    logic        we    [2];
    logic        stb   [2];
    logic        cyc   [2];
    logic        ack   [2];
    logic        err   [2];
    logic        busy  [2];

    int          checks;
    int          errors;
    int          cyc_cnt;
    int          ready [2];
    int          ws    [2];
    logic [31:0] mem_m [2][1024];
    logic [31:0] last_rd [2];
    exp_t        q [$];

    rv32im_wb_ram_slave #(.XLEN(32), .ADDR_WIDTH(10), .WAIT_STATES(1)) dut (
        .clk_i(clk), .clear_ni(clear_n), .adr_i(adr[0]), .dat_i(dat_w[0]),
        .dat_o(dat_r[0]), .sel_i(sel[0]), .we_i(we[0]), .stb_i(stb[0]),
        .cyc_i(cyc[0]), .ack_o(ack[0]), .err_o(err[0]), .busy_o(busy[0])
    );

    rv32im_wb_ram_slave #(.XLEN(32), .ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .clk_i(clk), .clear_ni(clear_n), .adr_i(adr[1]), .dat_i(dat_w[1]),
        .dat_o(dat_r[1]), .sel_i(sel[1]), .we_i(we[1]), .stb_i(stb[1]),
        .cyc_i(cyc[1]), .ack_o(ack[1]), .err_o(err[1]), .busy_o(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic bit sel_legal(input logic [3:0] s);
        return (s == 4'h1) || (s == 4'h2) || (s == 4'h4) || (s == 4'h8) ||
               (s == 4'h3) || (s == 4'hC) || (s == 4'hF);
    endfunction

    // Monitor: every ack/err must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (clear_n) begin
            for (int k = 0; k < 2; k++) begin
                if (ack[k] && err[k]) begin
                    chk("ack_err_exclusive", 32'(k), 32'hFFFF_FFFF);
                end
                if (ack[k] || err[k]) begin
                    if (q.size() == 0) begin
                        chk("unexpected_resp", 32'(k), 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("resp_instance", 32'(k), 32'(e.k));
                        chk("resp_is_err", 32'(err[k]), 32'(e.is_err));
                        chk("resp_cycle", 32'(cyc_cnt), 32'(e.cyc));
                        chk("resp_dat_o", dat_r[k], e.dat);
                    end
                end
            end
        end
    end

    // Issue one transfer; returns at the negedge where its response is visible
    task automatic xfer(input int k, input bit w, input logic [29:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        int   samp;
        int   resp;
        bit   legal;
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; dat_w[k] = d; sel[k] = s;
        legal = sel_legal(s) && (a < 30'd1024);
        samp  = (cyc_cnt + 1 > ready[k]) ? cyc_cnt + 1 : ready[k];
        resp  = legal ? samp + 1 + ws[k] : samp;
        if (legal) begin
            if (w) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) mem_m[k][a[9:0]][b*8 +: 8] = d[b*8 +: 8];
                end
            end else begin
                last_rd[k] = mem_m[k][a[9:0]];
            end
        end
        e.k = k; e.is_err = !legal; e.dat = last_rd[k]; e.cyc = resp;
        q.push_back(e);
        ready[k] = resp + 2;
        while (cyc_cnt < resp) begin
            @(negedge clk);
            if (cyc_cnt == samp) chk("busy_after_sample", 32'(busy[k]), 32'd1);
        end
    endtask

    task automatic idle(input int k, input int n);
        cyc[k] = 1'b0; stb[k] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0; cyc_cnt = 0;
        ws[0] = 1; ws[1] = 0;
        for (int k = 0; k < 2; k++) begin
            cyc[k] = 0; stb[k] = 0; we[k] = 0; adr[k] = '0; dat_w[k] = '0; sel[k] = '0;
            last_rd[k] = '0;
        end
        clear_n = 1'b0;
        repeat (3) @(negedge clk);
        clear_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_ack", 32'(ack[k]), 32'd0);
            chk("reset_err", 32'(err[k]), 32'd0);
            chk("reset_busy", 32'(busy[k]), 32'd0);
            chk("reset_dat_o", dat_r[k], 32'd0);
            ready[k] = cyc_cnt + 1;
        end

        // Word, byte and half writes to word 5
        xfer(0, 1, 30'd5, 32'hDEADBEEF, 4'hF);
        idle(0, 2);
        xfer(0, 0, 30'd5, 32'h0, 4'hF);
        xfer(0, 1, 30'd5, 32'h000000AA, 4'h1);
        xfer(0, 1, 30'd5, 32'h12340000, 4'hC);
        xfer(0, 0, 30'd5, 32'h0, 4'hF);
        chk("byte_half_merge", mem_m[0][5], 32'h1234BEAA);
        idle(0, 1);

        // Error cases: out of range and illegal lane pattern
        xfer(0, 0, 30'h400, 32'h0, 4'hF);
        xfer(0, 1, 30'd5, 32'hFFFFFFFF, 4'h6);
        idle(0, 1);
        xfer(0, 0, 30'd5, 32'h0, 4'hF);
        idle(0, 2);

        // Abort: cyc drops during WAIT of a write to word 7
        xfer(0, 1, 30'd7, 32'h11111111, 4'hF);
        idle(0, 2);
        cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 30'd7; dat_w[0] = 32'hFFFFFFFF; sel[0] = 4'hF;
        @(negedge clk);
        chk("abort_busy_wait", 32'(busy[0]), 32'd1);
        cyc[0] = 0; stb[0] = 0;
        @(negedge clk);
        chk("abort_busy_idle", 32'(busy[0]), 32'd0);
        chk("abort_dat_o_hold", dat_r[0], last_rd[0]);
        idle(0, 3);
        ready[0] = cyc_cnt + 1;
        xfer(0, 0, 30'd7, 32'h0, 4'hF);
        idle(0, 2);

        // Asynchronous reset in the middle of WAIT
        xfer(0, 1, 30'd9, 32'h22222222, 4'hF);
        idle(0, 2);
        cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 30'd9; dat_w[0] = 32'h33333333; sel[0] = 4'hF;
        @(posedge clk);
        #2 clear_n = 1'b0;
        #1;
        chk("midreset_ack", 32'(ack[0]), 32'd0);
        chk("midreset_err", 32'(err[0]), 32'd0);
        chk("midreset_busy", 32'(busy[0]), 32'd0);
        chk("midreset_dat_o", dat_r[0], 32'd0);
        last_rd[0] = '0; last_rd[1] = '0;
        cyc[0] = 0; stb[0] = 0;
        @(negedge clk);
        @(negedge clk);
        clear_n = 1'b1;
        ready[0] = cyc_cnt + 1;
        ready[1] = cyc_cnt + 1;
        xfer(0, 0, 30'd9, 32'h0, 4'hF);
        idle(0, 1);

        // Zero wait states: back-to-back writes then four back-to-back reads
        for (int i = 0; i < 4; i++) xfer(1, 1, 30'(i), $urandom, 4'hF);
        for (int i = 0; i < 4; i++) xfer(1, 0, 30'(3 - i), 32'h0, 4'hF);
        idle(1, 2);

        // Randomised traffic on the wait-state slave over a small word window
        for (int i = 0; i < 16; i++) xfer(0, 1, 30'(i), $urandom, 4'hF);
        for (int i = 0; i < 80; i++) begin
            logic [29:0] a;
            a = ($urandom_range(0, 9) == 0) ? 30'(1024 + $urandom_range(0, 5000)) : 30'($urandom_range(0, 15));
            xfer(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle(0, $urandom_range(1, 3));
        end
        idle(0, 4);

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the bench always ends on its own
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
